pipe_addsub: RTL and testbench

PIPE_ADDSUB -- requirements
Module: pipe_addsub

---
 rtl/pipe_addsub_if.sv | 27 ++
 rtl/pipe_addsub.sv | 120 ++++++++++++
 tb/tb_pipe_addsub.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_addsub_if.sv
// Handshake and operand/result bundle for the carry-pipelined adder/subtractor.
// The master drives operands and result back-pressure; the slave is the datapath.
interface pipe_addsub_if #(
   parameter int unsigned WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             addsub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ov_signed;
   logic             ov_unsigned;

   modport master (
      output in_valid, a, b, addsub, out_ready,
      input  in_ready, out_valid, sum, cout, ov_signed, ov_unsigned
   );

   modport slave (
      input  in_valid, a, b, addsub, out_ready,
      output in_ready, out_valid, sum, cout, ov_signed, ov_unsigned
   );
endinterface

// File: rtl/pipe_addsub.sv
// Carry-pipelined ripple-carry adder/subtractor: SEG bits per stage, operands skewed in,
// result slices deskewed out, whole pipeline frozen while a result waits on out_ready.
module pipe_addsub #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned SEG   = 4
) (
   input logic          clk,
   input logic          rst_n,
   pipe_addsub_if.slave bus
);
   localparam int unsigned STAGES = WIDTH / SEG;

   logic advance;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int unsigned LO  = k * SEG;
      localparam int unsigned REM = WIDTH - LO - SEG;

      logic [SEG-1:0]    a_sl;
      logic [SEG-1:0]    b_sl;
      logic [SEG-1:0]    b_eff;
      logic              carry_in;
      logic              mode_in;
      logic              valid_in;
      logic [SEG:0]      seg_sum;
      logic [LO+SEG-1:0] res_d;
      logic [LO+SEG-1:0] res_q;
      logic              valid_q;
      logic              carry_q;

      if (k == 0) begin : g_in
         // Subtraction is a + ~b + 1; the +1 enters here as the carry-in.
         assign a_sl     = bus.a[SEG-1:0];
         assign b_sl     = bus.b[SEG-1:0];
         assign mode_in  = bus.addsub;
         assign carry_in = !bus.addsub;
         assign valid_in = bus.in_valid;
         assign res_d    = seg_sum[SEG-1:0];
      end else begin : g_in
         assign a_sl     = g_stage[k-1].g_skew.a_rem_q[SEG-1:0];
         assign b_sl     = g_stage[k-1].g_skew.b_rem_q[SEG-1:0];
         assign mode_in  = g_stage[k-1].g_skew.mode_q;
         assign carry_in = g_stage[k-1].carry_q;
         assign valid_in = g_stage[k-1].valid_q;
         assign res_d    = {seg_sum[SEG-1:0], g_stage[k-1].res_q};
      end

      assign b_eff   = mode_in ? b_sl : ~b_sl;
      assign seg_sum = {1'b0, a_sl} + {1'b0, b_eff} + {{SEG{1'b0}}, carry_in};

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            valid_q <= 1'b0;
            carry_q <= 1'b0;
            res_q   <= '0;
         end else if (advance) begin
            valid_q <= valid_in;
            carry_q <= seg_sum[SEG];
            res_q   <= res_d;
         end
      end

      // Operand bits not yet summed ride along with their transaction, as does the mode.
      if (k < STAGES - 1) begin : g_skew
         logic [REM-1:0] a_rem_d;
         logic [REM-1:0] b_rem_d;
         logic [REM-1:0] a_rem_q;
         logic [REM-1:0] b_rem_q;
         logic           mode_q;

         if (k == 0) begin : g_src
            assign a_rem_d = bus.a[WIDTH-1:SEG];
            assign b_rem_d = bus.b[WIDTH-1:SEG];
         end else begin : g_src
            assign a_rem_d = g_stage[k-1].g_skew.a_rem_q[REM+SEG-1:SEG];
            assign b_rem_d = g_stage[k-1].g_skew.b_rem_q[REM+SEG-1:SEG];
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_rem_q <= '0;
               b_rem_q <= '0;
               mode_q  <= 1'b0;
            end else if (advance) begin
               a_rem_q <= a_rem_d;
               b_rem_q <= b_rem_d;
               mode_q  <= mode_in;
            end
         end
      end

      if (k == STAGES - 1) begin : g_flags
         logic msb_carry;
         logic ovs_q;
         logic ovu_q;

         // Carry into the MSB recovered from the MSB's sum bit and its two addend bits.
         assign msb_carry = a_sl[SEG-1] ^ b_eff[SEG-1] ^ seg_sum[SEG-1];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ovs_q <= 1'b0;
               ovu_q <= 1'b0;
            end else if (advance) begin
               ovs_q <= msb_carry ^ seg_sum[SEG];
               ovu_q <= mode_in ? seg_sum[SEG] : !seg_sum[SEG];
            end
         end
      end
   end

   assign advance         = !(g_stage[STAGES-1].valid_q && !bus.out_ready);
   assign bus.in_ready    = advance;
   assign bus.out_valid   = g_stage[STAGES-1].valid_q;
   assign bus.sum         = g_stage[STAGES-1].res_q;
   assign bus.cout        = g_stage[STAGES-1].carry_q;
   assign bus.ov_signed   = g_stage[STAGES-1].g_flags.ovs_q;
   assign bus.ov_unsigned = g_stage[STAGES-1].g_flags.ovu_q;

endmodule

// File: tb/tb_pipe_addsub.sv
// Bench for pipe_addsub: directed corner vectors, stall/back-pressure, mid-flight reset,
// a single-stage instance, and a long randomized run against an arithmetic reference model.
module tb_pipe_addsub;
   localparam int unsigned W      = 16;
   localparam int unsigned S      = 4;
   localparam int unsigned STAGES = W / S;

   typedef struct packed {
      logic [15:0] sum;
      logic        cout;
      logic        ovs;
      logic        ovu;
   } res_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   pipe_addsub_if #(.WIDTH(W)) bus  ();
   pipe_addsub_if #(.WIDTH(4)) bus4 ();

   pipe_addsub #(.WIDTH(W), .SEG(S)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
   pipe_addsub #(.WIDTH(4), .SEG(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

   // Reference: plain integer arithmetic on unsigned and signed interpretations.
   function automatic res_t model(input int w, input longint a, input longint b, input bit add);
      res_t   r;
      longint m, half, sa, sb, sr, full;
      m    = (longint'(1) << w) - 1;
      half = longint'(1) << (w - 1);
      sa   = (a >= half) ? a - 2 * half : a;
      sb   = (b >= half) ? b - 2 * half : b;
      if (add) begin
         full  = a + b;
         r.cout = (full > m);
         r.ovu  = (full > m);
         sr     = sa + sb;
      end else begin
         full  = a - b;
         r.cout = (a >= b);
         r.ovu  = (a < b);
         sr     = sa - sb;
      end
      r.sum = 16'(full & m);
      r.ovs = (sr >= half) || (sr < -half);
      return r;
   endfunction

   task automatic idle();
      bus.in_valid   = 1'b0;
      bus.a          = '0;
      bus.b          = '0;
      bus.addsub     = 1'b0;
      bus.out_ready  = 1'b1;
      bus4.in_valid  = 1'b0;
      bus4.a         = '0;
      bus4.b         = '0;
      bus4.addsub    = 1'b0;
      bus4.out_ready = 1'b1;
   endtask

   task automatic test_reset();
      idle();
      #3;
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL reset out_valid: got %b expected 0", bus.out_valid);
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL reset in_ready: got %b expected 1", bus.in_ready);
      end
      checks++;
      if ({bus.sum, bus.cout, bus.ov_signed, bus.ov_unsigned} !== 19'h0) begin
         errors++;
         $display("FAIL reset fields: got %h expected 0",
                  {bus.sum, bus.cout, bus.ov_signed, bus.ov_unsigned});
      end
      checks++;
      if ({bus4.out_valid, bus4.in_ready, bus4.sum, bus4.cout} !== 7'b0100000) begin
         errors++;
         $display("FAIL reset narrow: got %b expected 0100000",
                  {bus4.out_valid, bus4.in_ready, bus4.sum, bus4.cout});
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Presents one operand set now; acceptance happens on the next rising edge.
   task automatic run_vec(input logic [15:0] a, input logic [15:0] b, input bit add,
                          input res_t exp, input string name);
      res_t obs;
      int   lat;
      bus.a = a; bus.b = b; bus.addsub = add; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL %s in_ready: got %b expected 1", name, bus.in_ready);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (lat != STAGES) begin
         errors++; $display("FAIL %s latency: got %0d expected %0d", name, lat, STAGES);
      end
      obs = '{sum: bus.sum, cout: bus.cout, ovs: bus.ov_signed, ovu: bus.ov_unsigned};
      checks++;
      if (obs !== exp) begin
         errors++; $display("FAIL %s result: got %h expected %h", name, obs, exp);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL %s duplicate: got out_valid %b expected 0", name, bus.out_valid);
      end
   endtask

   task automatic test_corner_vectors();
      run_vec(16'h7FFF, 16'h0001, 1'b1, '{sum: 16'h8000, cout: 1'b0, ovs: 1'b1, ovu: 1'b0}, "add_7fff_1");
      run_vec(16'h0003, 16'h0009, 1'b0, '{sum: 16'hFFFA, cout: 1'b0, ovs: 1'b0, ovu: 1'b1}, "sub_3_9");
      run_vec(16'hFFFF, 16'h0001, 1'b1, '{sum: 16'h0000, cout: 1'b1, ovs: 1'b0, ovu: 1'b1}, "add_ffff_1");
   endtask

   task automatic run_vec4(input logic [3:0] a, input logic [3:0] b, input bit add,
                           input logic [6:0] exp, input string name);
      bus4.a = a; bus4.b = b; bus4.addsub = add; bus4.in_valid = 1'b1; bus4.out_ready = 1'b1;
      @(posedge clk); #1;
      bus4.in_valid = 1'b0;
      checks++;
      if (bus4.out_valid !== 1'b1) begin
         errors++; $display("FAIL %s latency: got out_valid %b expected 1", name, bus4.out_valid);
      end
      checks++;
      if ({bus4.sum, bus4.cout, bus4.ov_signed, bus4.ov_unsigned} !== exp) begin
         errors++;
         $display("FAIL %s result: got %b expected %b", name,
                  {bus4.sum, bus4.cout, bus4.ov_signed, bus4.ov_unsigned}, exp);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_narrow();
      run_vec4(4'd13, 4'd8, 1'b1, {4'd5, 1'b1, 1'b1, 1'b1}, "narrow_add_13_8");
      run_vec4(4'd4, 4'd5, 1'b0, {4'd15, 1'b0, 1'b0, 1'b1}, "narrow_sub_4_5");
   endtask

   task automatic test_back_to_back();
      res_t        q[$];
      res_t        obs, prev, exp;
      logic [15:0] av[8];
      logic [15:0] bv[8];
      int          sent = 0, got = 0, stalled = 0;
      bit          prev_stall = 1'b0;
      for (int i = 0; i < 8; i++) begin
         av[i] = 16'($urandom);
         bv[i] = 16'($urandom);
      end
      for (int c = 0; c < 60 && got < 8; c++) begin
         bus.in_valid  = (sent < 8);
         bus.a         = (sent < 8) ? av[sent] : 16'h0;
         bus.b         = (sent < 8) ? bv[sent] : 16'h0;
         bus.addsub    = (sent % 2 == 0);
         bus.out_ready = !(c >= 5 && c <= 7);
         @(negedge clk);
         obs = '{sum: bus.sum, cout: bus.cout, ovs: bus.ov_signed, ovu: bus.ov_unsigned};
         checks++;
         if (bus.in_ready !== !(bus.out_valid && !bus.out_ready)) begin
            errors++; $display("FAIL b2b in_ready cycle %0d: got %b", c, bus.in_ready);
         end
         if (prev_stall) begin
            checks++;
            if (bus.out_valid !== 1'b1 || obs !== prev) begin
               errors++; $display("FAIL b2b hold cycle %0d: got %h expected %h", c, obs, prev);
            end
         end
         if (bus.in_ready === 1'b0) stalled++;
         prev_stall = bus.out_valid && !bus.out_ready;
         prev       = obs;
         if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (q.size() == 0) begin
               errors++; $display("FAIL b2b spurious: got %h expected no result", obs);
            end else begin
               exp = q.pop_front();
               if (obs !== exp) begin
                  errors++; $display("FAIL b2b result %0d: got %h expected %h", got, obs, exp);
               end
            end
            got++;
         end
         if (bus.in_valid && bus.in_ready) begin
            q.push_back(model(16, longint'(av[sent]), longint'(bv[sent]), sent % 2 == 0));
            sent++;
         end
         @(posedge clk); #1;
      end
      checks++;
      if (got != 8 || sent != 8 || q.size() != 0) begin
         errors++; $display("FAIL b2b count: got %0d/%0d expected 8/8", sent, got);
      end
      checks++;
      if (stalled != 3) begin
         errors++; $display("FAIL b2b stall cycles: got %0d expected 3", stalled);
      end
      idle();
   endtask

   task automatic test_reset_midflight();
      int spurious = 0;
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         bus.a        = 16'($urandom);
         bus.b        = 16'($urandom);
         bus.addsub   = 1'($urandom);
         @(posedge clk); #1;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1) begin
         errors++; $display("FAIL midreset precondition: got out_valid %b expected 1", bus.out_valid);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.sum !== 16'h0) begin
         errors++;
         $display("FAIL midreset async: got valid %b ready %b sum %h expected 0 1 0000",
                  bus.out_valid, bus.in_ready, bus.sum);
      end
      @(negedge clk);
      rst_n         = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid !== 1'b0) spurious++;
      end
      checks++;
      if (spurious != 0) begin
         errors++; $display("FAIL midreset leftover: got %0d valid cycles expected 0", spurious);
      end
   endtask

   task automatic test_random();
      res_t q[$];
      res_t obs, prev, exp;
      int   accepted = 0;
      bit   prev_stall = 1'b0;
      bit   driving;
      for (int c = 0; c < 60000; c++) begin
         driving = (accepted < 10000);
         if (!driving && q.size() == 0) break;
         bus.in_valid  = driving && ($urandom_range(0, 3) != 0);
         bus.a         = 16'($urandom);
         bus.b         = 16'($urandom);
         bus.addsub    = 1'($urandom);
         bus.out_ready = driving ? ($urandom_range(0, 3) != 0) : 1'b1;
         @(negedge clk);
         obs = '{sum: bus.sum, cout: bus.cout, ovs: bus.ov_signed, ovu: bus.ov_unsigned};
         checks++;
         if (bus.in_ready !== !(bus.out_valid && !bus.out_ready)) begin
            errors++; $display("FAIL rand in_ready cycle %0d: got %b", c, bus.in_ready);
         end
         if (prev_stall) begin
            checks++;
            if (bus.out_valid !== 1'b1 || obs !== prev) begin
               errors++; $display("FAIL rand hold cycle %0d: got %h expected %h", c, obs, prev);
            end
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         prev       = obs;
         if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (q.size() == 0) begin
               errors++; $display("FAIL rand spurious cycle %0d: got %h expected no result", c, obs);
            end else begin
               exp = q.pop_front();
               if (obs !== exp) begin
                  errors++; $display("FAIL rand result cycle %0d: got %h expected %h", c, obs, exp);
               end
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            q.push_back(model(16, longint'(bus.a), longint'(bus.b), bus.addsub));
            accepted++;
         end
         @(posedge clk); #1;
      end
      checks++;
      if (accepted != 10000 || q.size() != 0 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rand completion: got %0d accepted %0d pending expected 10000 0",
                  accepted, q.size());
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_corner_vectors();
      test_narrow();
      test_back_to_back();
      test_reset_midflight();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
